// File: rtl/zeroriscy_sim_pkg.sv
// Shared constants for the zero-riscy simulation top: memory map, SRAM depth, lane count.
package zeroriscy_sim_pkg;

  localparam int          MMIO_BIT          = 31;
  localparam logic [31:0] TOHOST_ADDR0      = 32'h8000_1000;
  localparam logic [31:0] TOHOST_ADDR1      = 32'h8000_3000;
  localparam int          MEM_WORDS_DEFAULT = 16384;
  localparam int          BE_LANES          = 4;
  localparam logic [31:0] RESET_OFFSET      = 32'h0000_0080;

endpackage

// File: rtl/zeroriscy_core.sv
// Behavioural stand-in for the zero-riscy core: RV32I subset, one instruction at a time,
// with the core's instruction/data request-grant-rvalid bus ports and tie-off inputs.
module zeroriscy_core
  import zeroriscy_sim_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clock_en_i,
  input  logic        test_en_i,
  input  logic [3:0]  core_id_i,
  input  logic [5:0]  cluster_id_i,
  input  logic [31:0] boot_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  input  logic        irq_i,
  input  logic [4:0]  irq_id_i,
  output logic        irq_ack_o,
  output logic [4:0]  irq_id_o,
  input  logic        debug_req_i,
  output logic        debug_gnt_o,
  output logic        debug_rvalid_o,
  input  logic [14:0] debug_addr_i,
  input  logic        debug_we_i,
  input  logic [31:0] debug_wdata_i,
  output logic [31:0] debug_rdata_o,
  output logic        debug_halted_o,
  input  logic        debug_halt_i,
  input  logic        debug_resume_i,
  input  logic        fetch_enable_i,
  output logic        core_busy_o,
  input  logic        ext_perf_counters_i
);

  typedef enum logic [2:0] {S_START, S_IREQ, S_IWAIT, S_EXEC, S_DREQ, S_DWAIT, S_HALT} state_t;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_IMM = 7'b0010011,
                         OP_REG = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;

  state_t      state;
  logic [31:0] pc, ir;
  logic [31:0] rf [0:31];
  logic [4:0]  ld_rd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_u, imm_b, imm_j, ls_addr, alu_b, alu;
  logic signed [31:0] sra_v;
  logic [31:0] wb_val, next_pc, ld_word, ld_val;
  logic        wb_en, is_mem, illegal, taken, run;

  assign opc     = ir[6:0];
  assign f3      = ir[14:12];
  assign rd      = ir[11:7];
  assign rs1_v   = (ir[19:15] == 5'd0) ? 32'd0 : rf[ir[19:15]];
  assign rs2_v   = (ir[24:20] == 5'd0) ? 32'd0 : rf[ir[24:20]];
  assign imm_i   = {{20{ir[31]}}, ir[31:20]};
  assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_u   = {ir[31:12], 12'd0};
  assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign ls_addr = rs1_v + ((opc == OP_STORE) ? imm_s : imm_i);
  assign alu_b   = (opc == OP_REG) ? rs2_v : imm_i;
  assign sra_v   = $signed(rs1_v) >>> alu_b[4:0];
  assign run     = clock_en_i & fetch_enable_i & ~debug_halt_i & ~debug_req_i;

  always_comb begin
    alu = rs1_v + alu_b;
    case (f3)
      3'b000:  alu = (opc == OP_REG && ir[30]) ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001:  alu = rs1_v << alu_b[4:0];
      3'b010:  alu = {31'd0, $signed(rs1_v) < $signed(alu_b)};
      3'b011:  alu = {31'd0, rs1_v < alu_b};
      3'b100:  alu = rs1_v ^ alu_b;
      3'b101:  alu = ir[30] ? $unsigned(sra_v) : rs1_v >> alu_b[4:0];
      3'b110:  alu = rs1_v | alu_b;
      default: alu = rs1_v & alu_b;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  taken = (rs1_v == rs2_v);
      3'b001:  taken = (rs1_v != rs2_v);
      3'b100:  taken = ($signed(rs1_v) < $signed(rs2_v));
      3'b101:  taken = ($signed(rs1_v) >= $signed(rs2_v));
      3'b110:  taken = (rs1_v < rs2_v);
      3'b111:  taken = (rs1_v >= rs2_v);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    wb_en   = 1'b0;
    wb_val  = alu;
    next_pc = pc + 32'd4;
    is_mem  = 1'b0;
    illegal = 1'b0;
    case (opc)
      OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
      OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
      OP_JAL:   begin wb_en = 1'b1; wb_val = pc + 32'd4; next_pc = pc + imm_j; end
      OP_JALR:  begin wb_en = 1'b1; wb_val = pc + 32'd4; next_pc = (rs1_v + imm_i) & ~32'd1; end
      OP_BR:    if (taken) next_pc = pc + imm_b;
      OP_IMM, OP_REG: wb_en = 1'b1;
      OP_LOAD, OP_STORE: is_mem = 1'b1;
      default:  illegal = 1'b1;
    endcase
  end

  // Load data is taken from the addressed lane(s) of the returned word.
  assign ld_word = data_rdata_i >> {ld_off, 3'b000};
  always_comb begin
    case (ld_f3)
      3'b000:  ld_val = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_val = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_val = {24'd0, ld_word[7:0]};
      3'b101:  ld_val = {16'd0, ld_word[15:0]};
      default: ld_val = ld_word;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= S_START;
      pc           <= boot_addr_i + RESET_OFFSET;
      ir           <= '0;
      instr_req_o  <= 1'b0;
      instr_addr_o <= '0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      ld_rd        <= '0;
      ld_f3        <= '0;
      ld_off       <= '0;
    end else begin
      case (state)
        S_START: if (run) begin
          instr_req_o  <= 1'b1;
          instr_addr_o <= pc;
          state        <= S_IREQ;
        end
        S_IREQ: if (instr_gnt_i) begin
          instr_req_o <= 1'b0;
          state       <= S_IWAIT;
        end
        S_IWAIT: if (instr_rvalid_i) begin
          ir    <= instr_rdata_i;
          state <= S_EXEC;
        end
        S_EXEC: if (run) begin
          if (illegal) begin
            state <= S_HALT;
          end else if (is_mem) begin
            data_req_o   <= 1'b1;
            data_we_o    <= opc[5];
            data_addr_o  <= ls_addr;
            data_be_o    <= !opc[5] ? 4'hF : f3[1] ? 4'hF :
                            (f3[0] ? 4'b0011 : 4'b0001) << ls_addr[1:0];
            data_wdata_o <= rs2_v << {ls_addr[1:0], 3'b000};
            ld_rd        <= rd;
            ld_f3        <= f3;
            ld_off       <= ls_addr[1:0];
            state        <= S_DREQ;
          end else begin
            if (wb_en && rd != 5'd0) rf[rd] <= wb_val;
            pc           <= next_pc;
            instr_req_o  <= 1'b1;
            instr_addr_o <= next_pc;
            state        <= S_IREQ;
          end
        end
        S_DREQ: if (data_gnt_i) begin
          data_req_o <= 1'b0;
          state      <= S_DWAIT;
        end
        S_DWAIT: if (data_rvalid_i) begin
          if (data_err_i) begin
            state <= S_HALT;
          end else begin
            if (!data_we_o && ld_rd != 5'd0) rf[ld_rd] <= ld_val;
            pc           <= pc + 32'd4;
            instr_req_o  <= 1'b1;
            instr_addr_o <= pc + 32'd4;
            state        <= S_IREQ;
          end
        end
        S_HALT: if (debug_resume_i) begin
          pc    <= pc + 32'd4;
          state <= S_START;
        end
        default: state <= S_START;
      endcase
    end
  end

  assign debug_halted_o = (state == S_HALT);
  assign core_busy_o    = (state != S_HALT) && (state != S_START);
  assign debug_gnt_o    = 1'b0;
  assign debug_rvalid_o = 1'b0;
  assign debug_rdata_o  = '0;
  assign irq_ack_o      = 1'b0;
  assign irq_id_o       = '0;

  logic unused_inputs;
  assign unused_inputs = ^{test_en_i, core_id_i, cluster_id_i, irq_i, irq_id_i, debug_addr_i,
                           debug_we_i, debug_wdata_i, ext_perf_counters_i};

endmodule

// File: rtl/zeroriscy_sim_top_dp_sram.sv
// Dual-port word SRAM: port A synchronous read, port B synchronous read/byte-masked write.
// Same-word A read and B write in one cycle returns the old word on A. No reset on the array.
module dp_sram
  import zeroriscy_sim_pkg::*;
#(
  parameter int WORDS = MEM_WORDS_DEFAULT
) (
  input  logic                clk,
  input  logic                a_en,
  input  logic [13:0]         a_idx,
  output logic [31:0]         a_rdata,
  input  logic                b_en,
  input  logic                b_we,
  input  logic [BE_LANES-1:0] b_be,
  input  logic [13:0]         b_idx,
  input  logic [31:0]         b_wdata,
  output logic [31:0]         b_rdata
);

  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0]   mem [0:WORDS-1];
  logic [AW-1:0] a_row, b_row;

  // Indices wrap modulo the depth so a reduced-depth build aliases instead of overflowing.
  assign a_row = AW'(a_idx % WORDS);
  assign b_row = AW'(b_idx % WORDS);

  always_ff @(posedge clk) begin
    if (a_en) a_rdata <= mem[a_row];
    if (b_en) begin
      b_rdata <= mem[b_row];
      if (b_we) begin
        for (int i = 0; i < BE_LANES; i++) begin
          if (b_be[i]) mem[b_row][8*i +: 8] <= b_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/zeroriscy_sim_top.sv
// Simulation top: zero-riscy core plus one dual-port SRAM for code and data, single-cycle grant,
// rvalid one cycle after every grant; addresses with bit 31 set form a write-discard, read-zero hole.
module zeroriscy_sim_top
  import zeroriscy_sim_pkg::*;
#(
  parameter int          MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter logic [3:0]  CORE_ID    = 4'd0,
  parameter logic [5:0]  CLUSTER_ID = 6'd0
) (
  input logic clk,
  input logic reset
);

  logic        instr_req, instr_gnt, instr_rvalid;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata, sram_b_rdata;
  logic        data_mmio_q, sram_b_en;

  logic        irq_ack, debug_gnt, debug_rvalid, debug_halted, core_busy;
  logic [4:0]  irq_id;
  logic [31:0] debug_rdata;

  assign instr_gnt = instr_req;
  assign data_gnt  = data_req;
  // Gating with reset keeps a request still on the bus at a reset edge from committing.
  assign sram_b_en  = data_gnt & ~data_addr[MMIO_BIT] & reset;
  assign data_rdata = data_mmio_q ? 32'd0 : sram_b_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_rvalid <= 1'b0;
      data_rvalid  <= 1'b0;
      data_mmio_q  <= 1'b0;
    end else begin
      instr_rvalid <= instr_gnt;
      data_rvalid  <= data_gnt;
      if (data_gnt) data_mmio_q <= data_addr[MMIO_BIT];
    end
  end

  zeroriscy_core zeroriscy_core (
    .clk_i               (clk),
    .rst_ni              (reset),
    .clock_en_i          (1'b1),
    .test_en_i           (1'b0),
    .core_id_i           (CORE_ID),
    .cluster_id_i        (CLUSTER_ID),
    .boot_addr_i         (BOOT_ADDR),
    .instr_req_o         (instr_req),
    .instr_gnt_i         (instr_gnt),
    .instr_rvalid_i      (instr_rvalid),
    .instr_addr_o        (instr_addr),
    .instr_rdata_i       (instr_rdata),
    .data_req_o          (data_req),
    .data_gnt_i          (data_gnt),
    .data_rvalid_i       (data_rvalid),
    .data_we_o           (data_we),
    .data_be_o           (data_be),
    .data_addr_o         (data_addr),
    .data_wdata_o        (data_wdata),
    .data_rdata_i        (data_rdata),
    .data_err_i          (1'b0),
    .irq_i               (1'b0),
    .irq_id_i            (5'd0),
    .irq_ack_o           (irq_ack),
    .irq_id_o            (irq_id),
    .debug_req_i         (1'b0),
    .debug_gnt_o         (debug_gnt),
    .debug_rvalid_o      (debug_rvalid),
    .debug_addr_i        (15'd0),
    .debug_we_i          (1'b0),
    .debug_wdata_i       (32'd0),
    .debug_rdata_o       (debug_rdata),
    .debug_halted_o      (debug_halted),
    .debug_halt_i        (1'b0),
    .debug_resume_i      (1'b0),
    .fetch_enable_i      (1'b1),
    .core_busy_o         (core_busy),
    .ext_perf_counters_i (1'b0)
  );

  dp_sram #(.WORDS(MEM_WORDS)) zeroriscy_dp_sram (
    .clk     (clk),
    .a_en    (instr_gnt),
    .a_idx   (instr_addr[15:2]),
    .a_rdata (instr_rdata),
    .b_en    (sram_b_en),
    .b_we    (data_we),
    .b_be    (data_be),
    .b_idx   (data_addr[15:2]),
    .b_wdata (data_wdata),
    .b_rdata (sram_b_rdata)
  );

  logic unused_core_outs;
  assign unused_core_outs = ^{irq_ack, irq_id, debug_gnt, debug_rvalid, debug_rdata, debug_halted,
                              core_busy, data_addr[30:16], data_addr[1:0], instr_addr[31:16],
                              instr_addr[1:0]};

endmodule

// File: tb/tb_zeroriscy_sim_top.sv
// Directed bench for zeroriscy_sim_top: preloads small programs and checks the bus by hierarchy.
module tb_zeroriscy_sim_top;
  import zeroriscy_sim_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [31:0] JAL_SELF = 32'h0000_006F;

  zeroriscy_sim_top dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] sb(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b0100011};
  endfunction

  task automatic poke(input int idx, input logic [31:0] val);
    dut.zeroriscy_dp_sram.mem[idx] = val;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 16'h20; i < 16'h30; i++) poke(i, 32'd0);
  endtask

  task automatic wait_ireq(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dut.zeroriscy_core.instr_req_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_dreq(input bit we, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (dut.zeroriscy_core.data_req_o && dut.zeroriscy_core.data_we_o == we) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (dut.zeroriscy_core.instr_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_instr_req: got %b expected 0", dut.zeroriscy_core.instr_req_o); end
    n_checks++; if (dut.zeroriscy_core.data_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_data_req: got %b expected 0", dut.zeroriscy_core.data_req_o); end
    n_checks++; if (dut.zeroriscy_core.instr_rvalid_i !== 1'b0) begin n_fail++; $display("FAIL reset_instr_rvalid: got %b expected 0", dut.zeroriscy_core.instr_rvalid_i); end
    n_checks++; if (dut.zeroriscy_core.data_rvalid_i !== 1'b0) begin n_fail++; $display("FAIL reset_data_rvalid: got %b expected 0", dut.zeroriscy_core.data_rvalid_i); end
  endtask

  task automatic test_boot_loop();
    bit ok;
    int bad, nreq;
    hold_reset();
    poke(16'h20, JAL_SELF);
    reset = 1'b1;
    wait_ireq(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL boot_fetch: got no request expected request within 60 cycles"); end
    n_checks++; if (dut.zeroriscy_core.instr_addr_o !== 32'h80) begin n_fail++; $display("FAIL boot_addr: got %h expected %h", dut.zeroriscy_core.instr_addr_o, 32'h80); end
    n_checks++; if (dut.zeroriscy_core.instr_gnt_i !== 1'b1) begin n_fail++; $display("FAIL boot_gnt: got %b expected 1", dut.zeroriscy_core.instr_gnt_i); end
    n_checks++; if (dut.zeroriscy_core.instr_rvalid_i !== 1'b0) begin n_fail++; $display("FAIL boot_rvalid_early: got %b expected 0", dut.zeroriscy_core.instr_rvalid_i); end
    @(negedge clk);
    n_checks++; if (dut.zeroriscy_core.instr_rvalid_i !== 1'b1) begin n_fail++; $display("FAIL boot_rvalid: got %b expected 1", dut.zeroriscy_core.instr_rvalid_i); end
    n_checks++; if (dut.zeroriscy_core.instr_rdata_i !== JAL_SELF) begin n_fail++; $display("FAIL boot_rdata: got %h expected %h", dut.zeroriscy_core.instr_rdata_i, JAL_SELF); end
    @(negedge clk);
    n_checks++; if (dut.zeroriscy_core.instr_rvalid_i !== 1'b0) begin n_fail++; $display("FAIL boot_rvalid_pulse: got %b expected 0", dut.zeroriscy_core.instr_rvalid_i); end
    bad = 0; nreq = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dut.zeroriscy_core.instr_req_o) begin
        nreq++;
        if (dut.zeroriscy_core.instr_addr_o !== 32'h80) bad++;
      end
      if (dut.zeroriscy_core.data_req_o) bad++;
    end
    n_checks++; if (bad != 0 || nreq < 5) begin n_fail++; $display("FAIL boot_loop: got %0d bad of %0d fetches expected 0 bad and >=5 fetches", bad, nreq); end
  endtask

  task automatic test_tohost();
    bit ok;
    hold_reset();
    poke(16'h20, addi(5'd10, 5'd0, 12'd1));
    poke(16'h21, lui(5'd5, 20'h80001));
    poke(16'h22, sw(5'd10, 5'd5, 12'd0));
    poke(16'h23, JAL_SELF);
    poke(16'h400, 32'h5A5A_5A5A);
    reset = 1'b1;
    wait_dreq(1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL tohost_req: got no write expected write within 200 cycles"); end
    n_checks++; if (dut.zeroriscy_core.data_addr_o !== TOHOST_ADDR0) begin n_fail++; $display("FAIL tohost_addr: got %h expected %h", dut.zeroriscy_core.data_addr_o, TOHOST_ADDR0); end
    n_checks++; if (dut.zeroriscy_core.data_wdata_o !== 32'd1) begin n_fail++; $display("FAIL tohost_wdata: got %h expected %h", dut.zeroriscy_core.data_wdata_o, 32'd1); end
    @(negedge clk);
    n_checks++; if (dut.zeroriscy_core.data_rvalid_i !== 1'b1) begin n_fail++; $display("FAIL tohost_rvalid: got %b expected 1", dut.zeroriscy_core.data_rvalid_i); end
    repeat (10) @(negedge clk);
    n_checks++; if (dut.zeroriscy_dp_sram.mem[16'h400] !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL tohost_no_alias: got %h expected %h", dut.zeroriscy_dp_sram.mem[16'h400], 32'h5A5A_5A5A); end
    n_checks++; if (dut.zeroriscy_dp_sram.mem[16'h22] !== 32'h00A2_A023) begin n_fail++; $display("FAIL tohost_code_intact: got %h expected %h", dut.zeroriscy_dp_sram.mem[16'h22], 32'h00A2_A023); end
  endtask

  task automatic test_byte_write();
    bit ok;
    hold_reset();
    poke(16'h40, 32'd0);
    poke(16'h20, lui(5'd5, 20'h11223));
    poke(16'h21, addi(5'd5, 5'd5, 12'h344));
    poke(16'h22, addi(5'd6, 5'd0, 12'h100));
    poke(16'h23, sw(5'd5, 5'd6, 12'd0));
    poke(16'h24, addi(5'd10, 5'd0, 12'h0AA));
    poke(16'h25, sb(5'd10, 5'd6, 12'd1));
    poke(16'h26, lw(5'd11, 5'd6, 12'd0));
    poke(16'h27, JAL_SELF);
    reset = 1'b1;
    wait_dreq(1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL byte_lw_req: got no read expected read within 200 cycles"); end
    n_checks++; if (dut.zeroriscy_dp_sram.mem[16'h40] !== 32'h1122_AA44) begin n_fail++; $display("FAIL byte_mem: got %h expected %h", dut.zeroriscy_dp_sram.mem[16'h40], 32'h1122_AA44); end
    @(negedge clk);
    n_checks++; if (dut.zeroriscy_core.data_rvalid_i !== 1'b1) begin n_fail++; $display("FAIL byte_lw_rvalid: got %b expected 1", dut.zeroriscy_core.data_rvalid_i); end
    n_checks++; if (dut.zeroriscy_core.data_rdata_i !== 32'h1122_AA44) begin n_fail++; $display("FAIL byte_lw_rdata: got %h expected %h", dut.zeroriscy_core.data_rdata_i, 32'h1122_AA44); end
  endtask

  task automatic test_mmio_read();
    bit ok;
    hold_reset();
    poke(16'hC00, 32'hCAFE_F00D);
    poke(16'h20, lui(5'd5, 20'h80003));
    poke(16'h21, lw(5'd10, 5'd5, 12'd0));
    poke(16'h22, JAL_SELF);
    reset = 1'b1;
    wait_dreq(1'b0, ok);
    n_checks++; if (!ok || dut.zeroriscy_core.data_addr_o !== TOHOST_ADDR1) begin n_fail++; $display("FAIL mmio_addr: got %h expected %h", dut.zeroriscy_core.data_addr_o, TOHOST_ADDR1); end
    @(negedge clk);
    n_checks++; if (dut.zeroriscy_core.data_rvalid_i !== 1'b1) begin n_fail++; $display("FAIL mmio_rvalid: got %b expected 1", dut.zeroriscy_core.data_rvalid_i); end
    n_checks++; if (dut.zeroriscy_core.data_rdata_i !== 32'd0) begin n_fail++; $display("FAIL mmio_rdata: got %h expected %h", dut.zeroriscy_core.data_rdata_i, 32'd0); end
  endtask

  task automatic test_alias();
    bit ok;
    hold_reset();
    poke(16'h80, 32'd0);
    poke(16'h20, lui(5'd5, 20'h00010));
    poke(16'h21, addi(5'd5, 5'd5, 12'h200));
    poke(16'h22, lui(5'd10, 20'hDEADC));
    poke(16'h23, addi(5'd10, 5'd10, 12'hEEF));
    poke(16'h24, sw(5'd10, 5'd5, 12'd0));
    poke(16'h25, JAL_SELF);
    reset = 1'b1;
    wait_dreq(1'b1, ok);
    n_checks++; if (!ok || dut.zeroriscy_core.data_addr_o !== 32'h0001_0200) begin n_fail++; $display("FAIL alias_addr: got %h expected %h", dut.zeroriscy_core.data_addr_o, 32'h0001_0200); end
    repeat (2) @(negedge clk);
    n_checks++; if (dut.zeroriscy_dp_sram.mem[16'h80] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alias_mem: got %h expected %h", dut.zeroriscy_dp_sram.mem[16'h80], 32'hDEAD_BEEF); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    repeat (5) @(negedge clk);
    wait_ireq(ok);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (dut.zeroriscy_core.instr_rvalid_i !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid: got %b expected 0", dut.zeroriscy_core.instr_rvalid_i); end
    n_checks++; if (dut.zeroriscy_core.instr_req_o !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b expected 0", dut.zeroriscy_core.instr_req_o); end
    reset = 1'b1;
    n_checks++; if (dut.zeroriscy_dp_sram.mem[16'h80] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL midrst_mem: got %h expected %h", dut.zeroriscy_dp_sram.mem[16'h80], 32'hDEAD_BEEF); end
    wait_ireq(ok);
    n_checks++; if (!ok || dut.zeroriscy_core.instr_addr_o !== 32'h80) begin n_fail++; $display("FAIL midrst_refetch: got %h expected %h", dut.zeroriscy_core.instr_addr_o, 32'h80); end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS_DEFAULT; i++) dut.zeroriscy_dp_sram.mem[i] = 32'd0;
    test_reset();
    test_boot_loop();
    test_tohost();
    test_byte_write();
    test_mmio_read();
    test_alias();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
